// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Brief    : Shared types and grant-selection helper for mem_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  // Sequencer states: one outstanding memory transaction at a time
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  // Which requester owns the in-flight transaction
  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  // Round-robin pick: a lone requester wins, a tie goes to whoever did not win last
  function automatic owner_e grant_pick(input logic   ifu_v,
                                        input logic   lsu_v,
                                        input owner_e last);
    owner_e win;
    win = OWN_IFU;
    if (ifu_v && lsu_v) begin
      if (last == OWN_IFU) win = OWN_LSU;
      else                 win = OWN_IFU;
    end else if (lsu_v) begin
      win = OWN_LSU;
    end
    return win;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Brief    : Two-requester (IFU/LSU) valid/ready arbiter onto a single memory
//             port. Round-robin grant, single outstanding transaction.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // IFU side
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  input  logic                ifu_resp_ready,
  output logic [DATA_W-1:0]   ifu_rdata,
  // LSU side
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  input  logic                lsu_resp_ready,
  output logic [DATA_W-1:0]   lsu_rdata,
  // Memory side
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  output logic                mem_resp_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  state_e              r_state;
  state_e              w_state_nxt;
  owner_e              r_owner;
  owner_e              r_last_grant;
  owner_e              w_winner;
  logic                w_accept;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wen;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wmask;

  assign w_winner = grant_pick(ifu_req_valid, lsu_req_valid, r_last_grant);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state, grant and response routing
  always_comb begin
    w_state_nxt    = r_state;
    w_accept       = 1'b0;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    ifu_rdata      = '0;
    lsu_rdata      = '0;
    mem_req_valid  = 1'b0;
    mem_resp_ready = 1'b0;
    case (r_state)
      IDLE: begin
        if (ifu_req_valid || lsu_req_valid) begin
          if (w_winner == OWN_LSU) lsu_req_ready = 1'b1;
          else                     ifu_req_ready = 1'b1;
          w_accept    = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) w_state_nxt = RESP;
      end
      RESP: begin
        if (r_owner == OWN_LSU) begin
          mem_resp_ready = lsu_resp_ready;
          lsu_resp_valid = mem_resp_valid;
          lsu_rdata      = mem_rdata;
        end else begin
          mem_resp_ready = ifu_resp_ready;
          ifu_resp_valid = mem_resp_valid;
          ifu_rdata      = mem_rdata;
        end
        if (mem_resp_valid && mem_resp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture the winner's request fields on the IDLE handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner      <= OWN_IFU;
      r_last_grant <= OWN_IFU;
      r_addr       <= '0;
      r_wen        <= 1'b0;
      r_wdata      <= '0;
      r_wmask      <= '0;
    end else if (w_accept) begin
      r_owner      <= w_winner;
      r_last_grant <= w_winner;
      if (w_winner == OWN_LSU) begin
        r_addr  <= lsu_addr;
        r_wen   <= lsu_wen;
        r_wdata <= lsu_wdata;
        r_wmask <= lsu_wmask;
      end else begin
        // Fetches are always reads with no byte enables
        r_addr  <= ifu_addr;
        r_wen   <= 1'b0;
        r_wdata <= '0;
        r_wmask <= '0;
      end
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wen   = r_wen;
  assign mem_wdata = r_wdata;
  assign mem_wmask = r_wmask;
  assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Brief    : Directed self-checking bench for mem_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_addr       (ifu_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_resp_ready (ifu_resp_ready),
    .ifu_rdata      (ifu_rdata),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_addr       (lsu_addr),
    .lsu_wen        (lsu_wen),
    .lsu_wdata      (lsu_wdata),
    .lsu_wmask      (lsu_wmask),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_resp_ready (lsu_resp_ready),
    .lsu_rdata      (lsu_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_ready (mem_resp_ready),
    .mem_rdata      (mem_rdata),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then driven 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change
  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    ifu_req_valid = 0; ifu_addr = '0; ifu_resp_ready = 0;
    lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
    lsu_resp_ready = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    settle();

    // Reset state
    chk("rst_busy",     busy,           1'b0);
    chk("rst_mreqv",    mem_req_valid,  1'b0);
    chk("rst_mrespr",   mem_resp_ready, 1'b0);
    chk("rst_maddr",    mem_addr,       32'h0);
    chk("rst_ifu_rdy",  ifu_req_ready,  1'b0);
    chk("rst_lsu_rdy",  lsu_req_ready,  1'b0);

    // Spurious memory response in IDLE is ignored
    mem_resp_valid = 1'b1;
    settle();
    chk("spur_ifu_rv",  ifu_resp_valid, 1'b0);
    chk("spur_lsu_rv",  lsu_resp_valid, 1'b0);
    chk("spur_mrespr",  mem_resp_ready, 1'b0);
    tick();
    chk("spur_busy",    busy,           1'b0);

    // IFU-only fetch with zero-wait memory
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000; ifu_resp_ready = 1;
    mem_req_ready = 1; mem_resp_valid = 1; mem_rdata = 32'h0000_0413;
    settle();
    chk("f_ifu_rdy",    ifu_req_ready,  1'b1);
    chk("f_lsu_rdy",    lsu_req_ready,  1'b0);
    tick();
    ifu_req_valid = 0;
    settle();
    chk("f_mreqv",      mem_req_valid,  1'b1);
    chk("f_maddr",      mem_addr,       32'h8000_0000);
    chk("f_mwen",       mem_wen,        1'b0);
    chk("f_req_ifu_rv", ifu_resp_valid, 1'b0);
    tick();
    settle();
    chk("f_ifu_rv",     ifu_resp_valid, 1'b1);
    chk("f_ifu_rdata",  ifu_rdata,      32'h0000_0413);
    chk("f_mrespr",     mem_resp_ready, 1'b1);
    tick();
    settle();
    chk("f_busy_done",  busy,           1'b0);

    // Round-robin from reset with both requesters always valid
    rst = 1; tick(); rst = 0;
    ifu_req_valid = 1; ifu_addr = 32'h0000_1000;
    lsu_req_valid = 1; lsu_addr = 32'h0000_2000; lsu_wen = 0;
    lsu_resp_ready = 1;
    mem_rdata = 32'h0000_5555;
    for (int t = 0; t < 4; t++) begin
      settle();
      chk("rr_lsu_rdy", lsu_req_ready, (t % 2 == 0) ? 1'b1 : 1'b0);
      chk("rr_ifu_rdy", ifu_req_ready, (t % 2 == 0) ? 1'b0 : 1'b1);
      tick();
      settle();
      chk("rr_maddr",   mem_addr, (t % 2 == 0) ? 32'h0000_2000 : 32'h0000_1000);
      chk("rr_req_rdy", {ifu_req_ready, lsu_req_ready}, 2'b00);
      tick();
      settle();
      chk("rr_lsu_rv",  lsu_resp_valid, (t % 2 == 0) ? 1'b1 : 1'b0);
      chk("rr_ifu_rv",  ifu_resp_valid, (t % 2 == 0) ? 1'b0 : 1'b1);
      tick();
    end
    ifu_req_valid = 0;

    // LSU store with memory request back-pressure
    lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_1000;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
    mem_req_ready = 0; mem_resp_valid = 0;
    settle();
    chk("st_lsu_rdy", lsu_req_ready, 1'b1);
    tick();
    // Scramble the LSU inputs to prove the memory fields are latched
    lsu_req_valid = 0; lsu_addr = 32'h1111_1111; lsu_wdata = 32'h2222_2222;
    lsu_wmask = 4'h3; lsu_wen = 0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("st_mreqv",   mem_req_valid, 1'b1);
      chk("st_maddr",   mem_addr,      32'h8000_1000);
      chk("st_mwdata",  mem_wdata,     32'hDEAD_BEEF);
      chk("st_mwm_wen", {mem_wmask, mem_wen}, 5'b1111_1);
      chk("st_lsu_rv",  lsu_resp_valid, 1'b0);
      tick();
    end
    mem_req_ready = 1;
    settle();
    tick();
    settle();
    chk("st_resp_wait_rv", lsu_resp_valid, 1'b0);
    chk("st_resp_busy",    busy,           1'b1);
    mem_resp_valid = 1;
    settle();
    chk("st_lsu_rv1",      lsu_resp_valid, 1'b1);
    tick();
    settle();
    chk("st_busy_done",    busy,           1'b0);

    // LSU load with response back-pressure; IFU must be held off
    lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h8000_2000; lsu_wmask = 4'h0;
    lsu_resp_ready = 0;
    mem_req_ready = 1; mem_resp_valid = 1; mem_rdata = 32'h1234_5678;
    settle();
    chk("ld_lsu_rdy", lsu_req_ready, 1'b1);
    tick();
    lsu_req_valid = 0;
    ifu_req_valid = 1; ifu_addr = 32'h8000_0004;
    tick();
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("ld_mrespr0",  mem_resp_ready, 1'b0);
      chk("ld_busy",     busy,           1'b1);
      chk("ld_ifu_rdy0", ifu_req_ready,  1'b0);
      chk("ld_lsu_rv",   lsu_resp_valid, 1'b1);
      chk("ld_lsu_rd",   lsu_rdata,      32'h1234_5678);
      tick();
    end
    lsu_resp_ready = 1;
    settle();
    chk("ld_mrespr1", mem_resp_ready, 1'b1);
    tick();
    settle();
    chk("ld_ifu_rdy1", ifu_req_ready, 1'b1);

    // IFU request accepted, then reset lands while in REQ
    mem_req_ready = 0;
    tick();
    settle();
    chk("rq_mreqv",  mem_req_valid, 1'b1);
    chk("rq_maddr",  mem_addr,      32'h8000_0004);
    rst = 1; ifu_req_valid = 0;
    tick();
    rst = 0;
    settle();
    chk("rq_rst_busy",  busy,           1'b0);
    chk("rq_rst_mreqv", mem_req_valid,  1'b0);
    chk("rq_rst_ifurv", ifu_resp_valid, 1'b0);

    // Fresh IFU fetch after the aborted transaction
    ifu_req_valid = 1; ifu_addr = 32'h8000_0008; ifu_resp_ready = 1;
    mem_req_ready = 1; mem_resp_valid = 1; mem_rdata = 32'hCAFE_0001;
    settle();
    chk("nf_ifu_rdy", ifu_req_ready, 1'b1);
    tick();
    ifu_req_valid = 0;
    settle();
    chk("nf_maddr",   mem_addr, 32'h8000_0008);
    tick();
    settle();
    chk("nf_ifu_rv",  ifu_resp_valid, 1'b1);
    chk("nf_ifu_rd",  ifu_rdata,      32'hCAFE_0001);
    tick();
    settle();
    chk("nf_busy",    busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single memory port of the NPC core between the instruction fetch unit (IFU) and the load/store unit (LSU). It replaces the direct instruction fetch path and gives the control unit's load/store outputs a real bus. It is a valid/ready, single-outstanding-transaction sequencer with round-robin grant. It sits between the IFU/LSU and the memory model (DPI-backed or SRAM).

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; write mask width is DATA_W/8
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- ifu_req_valid  in  1  IFU fetch request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  fetch address
- ifu_resp_valid  out  1  fetch data valid
- ifu_resp_ready  in  1  IFU takes response
- ifu_rdata  out  DATA_W  fetched instruction
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted
- lsu_addr  in  ADDR_W  load/store address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  DATA_W  store data
- lsu_wmask  in  DATA_W/8  byte enables
- lsu_resp_valid  out  1  LSU response valid (loads and stores)
- lsu_resp_ready  in  1  LSU takes response
- lsu_rdata  out  DATA_W  load data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr / mem_wen / mem_wdata / mem_wmask  out  ADDR_W / 1 / DATA_W / DATA_W/8  latched request fields
- mem_resp_valid  in  1  memory response
- mem_resp_ready  out  1  arbiter takes response
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  state != IDLE

## Operation
- States: IDLE, REQ, RESP. Registers: state, owner (IFU/LSU), last_grant, latched addr/wen/wdata/wmask.
- IDLE: pick winner among valid requesters. Only one valid → that one. Both valid → the one not equal to last_grant. Winner's req_ready=1 combinationally; loser's req_ready=0. On handshake: latch fields, owner←winner, last_grant←winner, state→REQ.
- IFU requests latch wen=0, wmask=0, wdata=0.
- REQ: mem_req_valid=1 with latched fields held stable. On mem_req_ready → RESP.
- RESP: mem_resp_ready = owner's resp_ready. Owner's resp_valid = mem_resp_valid. Owner's rdata = mem_rdata (combinational pass-through). Non-owner resp_valid=0. On mem_resp_valid & mem_resp_ready → IDLE.
- Stores return a response; rdata is don't-care.
- Both req_ready are 0 outside IDLE. mem_resp_ready=0 outside RESP; mem_resp_valid in IDLE/REQ is ignored.

## Timing
- Reset: state=IDLE, owner=IFU, last_grant=IFU (first tie goes to LSU), latched fields=0. All valid/ready outputs 0 except combinational IDLE grants. busy=0.
- Minimum transaction: accept at cycle 0, mem_req_valid at cycle 1, response at cycle 2 (memory zero-wait), next accept at cycle 3.
- Back-pressure: mem_req_ready=0 holds REQ. Owner resp_ready=0 holds RESP; memory must hold mem_resp_valid/mem_rdata stable.
- Reset mid-transaction (REQ or RESP): next cycle IDLE, transaction dropped, no response delivered.
- A requester deasserting valid before handshake is allowed; no grant is recorded.

## Structure
- Package mem_arb_pkg: state enum {IDLE, REQ, RESP}, owner enum {OWN_IFU, OWN_LSU}.
- Single module. Grant selection is a small combinational function in the package; no sub-module.

## Test plan
- IFU only, addr 0x80000000, zero-wait memory returning 0x00000413 → ifu_req_ready at cycle 0; mem_addr=0x80000000, mem_wen=0 at cycle 1; ifu_rdata=0x00000413 at cycle 2; busy low at cycle 3.
- Both valid from reset → LSU granted first, IFU next. Hold both valid for 4 transactions → grant order LSU, IFU, LSU, IFU.
- LSU store addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF. mem_req_ready low for 3 cycles → mem_* fields stable throughout; lsu_resp_valid only after mem_resp_valid.
- LSU load with lsu_resp_ready low for 2 cycles → mem_resp_ready low, state stays RESP. ifu_req_ready=0 despite ifu_req_valid=1.
- rst asserted during REQ → next cycle busy=0, mem_req_valid=0. A new IFU request is then accepted normally.
- Spurious mem_resp_valid=1 in IDLE → no resp_valid on either side, mem_resp_ready=0.
